// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    localparam int ADDR_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    // Instruction addresses are always word aligned.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl_adder.sv
// Plain modulo-2^W adder used for the sequential PC increment.
module fetch_ctrl_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues word fetches, registers returned
// instructions, and handles stalls and branch redirects with response drain.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [ADDR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [ADDR_W-1:0] imem_rdata,
    input  logic              stall_IF,
    input  logic              PCSrc,
    input  logic [ADDR_W-1:0] PC_Branch,
    output logic [ADDR_W-1:0] PC_IF,
    output logic [ADDR_W-1:0] INSTRUCTION_IF,
    output logic              instr_valid
);

    localparam logic [ADDR_W-1:0] RESET_ADDR = word_align(RESET_PC);

    fetch_state_e      state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [ADDR_W-1:0] target_reg, target_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] instr_reg, instr_next;
    logic              valid_reg, valid_next;

    logic [ADDR_W-1:0] addr_plus4;
    logic [ADDR_W-1:0] branch_tgt;
    logic              ack_live;

    fetch_ctrl_adder #(.W(ADDR_W)) u_pc_adder (
        .a   (addr_reg),
        .b   (ADDR_W'(4)),
        .sum (addr_plus4)
    );

    assign branch_tgt = word_align(PC_Branch);
    // An ack only means something while a request is on the bus.
    assign ack_live   = imem_ack && imem_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  state_next = ST_REQ;
            ST_REQ: begin
                if (PCSrc)
                    state_next = ack_live ? ST_REQ : ST_DRAIN;
                else if (ack_live)
                    state_next = stall_IF ? ST_HOLD : ST_REQ;
            end
            ST_HOLD: begin
                if (PCSrc || !stall_IF)
                    state_next = ST_REQ;
            end
            ST_DRAIN: begin
                if (ack_live)
                    state_next = ST_REQ;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req    = (state_reg == ST_REQ) || (state_reg == ST_DRAIN);
        addr_next   = addr_reg;
        pc_next     = pc_reg;
        instr_next  = instr_reg;
        valid_next  = valid_reg;
        target_next = PCSrc ? branch_tgt : target_reg;

        // A redirect flushes the IF outputs regardless of stall.
        if (PCSrc) begin
            valid_next = 1'b0;
            instr_next = NOP_INSTR;
        end

        case (state_reg)
            ST_IDLE, ST_HOLD: begin
                if (PCSrc)
                    addr_next = branch_tgt;
            end
            ST_REQ: begin
                if (PCSrc) begin
                    if (ack_live)
                        addr_next = branch_tgt;
                end else if (ack_live) begin
                    pc_next    = addr_reg;
                    instr_next = imem_rdata;
                    valid_next = 1'b1;
                    addr_next  = addr_plus4;
                end
            end
            ST_DRAIN: begin
                // The newest redirect wins even if it lands with the drained ack.
                if (ack_live)
                    addr_next = PCSrc ? branch_tgt : target_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_reg   <= RESET_ADDR;
            target_reg <= '0;
            pc_reg     <= RESET_PC;
            instr_reg  <= NOP_INSTR;
            valid_reg  <= 1'b0;
        end else begin
            addr_reg   <= addr_next;
            target_reg <= target_next;
            pc_reg     <= pc_next;
            instr_reg  <= instr_next;
            valid_reg  <= valid_next;
        end
    end

    assign imem_addr      = addr_reg;
    assign PC_IF          = pc_reg;
    assign INSTRUCTION_IF = instr_reg;
    assign instr_valid    = valid_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b1;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall_IF = 1'b0;
    logic        PCSrc = 1'b0;
    logic [31:0] PC_Branch = 32'h0;
    logic [31:0] PC_IF;
    logic [31:0] INSTRUCTION_IF;
    logic        instr_valid;

    logic        w_reset = 1'b0;
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_pc;
    logic [31:0] w_instr;
    logic        w_valid;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .stall_IF       (stall_IF),
        .PCSrc          (PCSrc),
        .PC_Branch      (PC_Branch),
        .PC_IF          (PC_IF),
        .INSTRUCTION_IF (INSTRUCTION_IF),
        .instr_valid    (instr_valid)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) u_wrap (
        .clk            (clk),
        .reset          (w_reset),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_ack       (1'b1),
        .imem_rdata     (32'h1234_5678),
        .stall_IF       (1'b0),
        .PCSrc          (1'b0),
        .PC_Branch      (32'h0),
        .PC_IF          (w_pc),
        .INSTRUCTION_IF (w_instr),
        .instr_valid    (w_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a fetch stream with at most one request in flight,
    // a "drop next response" flag after a redirect, and the IF output registers.
    logic        m_started, m_busy, m_drop, m_valid;
    logic [31:0] m_addr, m_redirect, m_pc, m_instr;

    task automatic model_step();
        logic [31:0] tgt;
        logic        acked;
        if (!reset) begin
            m_started = 0; m_busy = 0; m_drop = 0; m_valid = 0;
            m_addr = RST_PC; m_redirect = 0; m_pc = RST_PC; m_instr = NOP;
            return;
        end
        tgt   = {PC_Branch[31:2], 2'b00};
        acked = m_busy && imem_ack;
        if (PCSrc) begin
            m_valid = 0;
            m_instr = NOP;
        end
        if (!m_started) begin
            m_started = 1;
            m_busy    = 1;
            if (PCSrc) m_addr = tgt;
        end else if (m_drop) begin
            if (PCSrc) m_redirect = tgt;
            if (acked) begin
                m_drop = 0;
                m_addr = m_redirect;
            end
        end else if (PCSrc) begin
            if (acked || !m_busy) begin
                m_busy = 1;
                m_addr = tgt;
            end else begin
                m_drop     = 1;
                m_redirect = tgt;
            end
        end else if (acked) begin
            m_pc    = m_addr;
            m_instr = imem_rdata;
            m_valid = 1;
            m_addr  = m_addr + 32'd4;
            m_busy  = !stall_IF;
        end else if (!m_busy && !stall_IF) begin
            m_busy = 1;
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        check("cmp_imem_req",   {31'b0, imem_req},    {31'b0, m_busy});
        check("cmp_imem_addr",  imem_addr,            m_addr);
        check("cmp_addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
        check("cmp_pc_if",      PC_IF,                m_pc);
        check("cmp_instr_if",   INSTRUCTION_IF,       m_instr);
        check("cmp_valid",      {31'b0, instr_valid}, {31'b0, m_valid});
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        step();
        step();
        check("rst_req",   {31'b0, imem_req}, 32'h0);
        check("rst_addr",  imem_addr,         32'h0);
        check("rst_pc",    PC_IF,             32'h0);
        check("rst_instr", INSTRUCTION_IF,    NOP);
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        reset   = 1'b1;
        w_reset = 1'b1;

        step();                                   // first request at reset PC
        check("s35_addr0", imem_addr, 32'h0);
        check("s35_req",   {31'b0, imem_req}, 32'h1);
        check("s35_novalid", {31'b0, instr_valid}, 32'h0);
        check("s40_addr0", w_addr, 32'hFFFF_FFFC);
        imem_rdata = 32'hC0DE_0000;
        step();
        check("s35_addr4",  imem_addr, 32'h4);
        check("s35_valid",  {31'b0, instr_valid}, 32'h1);
        check("s35_instr0", INSTRUCTION_IF, 32'hC0DE_0000);
        check("s40_wrap",   w_addr, 32'h0000_0000);
        check("s40_pc",     w_pc, 32'hFFFF_FFFC);
        check("s40_instr",  w_instr, 32'h1234_5678);

        stall_IF   = 1'b1;                        // capture 0x4 while stalled
        imem_rdata = 32'hC0DE_0004;
        step();
        imem_rdata = 32'hDEAD_BEEF;               // out-of-protocol acks while held
        for (int i = 0; i < 5; i++) begin
            check("s37_pc",    PC_IF, 32'h4);
            check("s37_instr", INSTRUCTION_IF, 32'hC0DE_0004);
            check("s37_req",   {31'b0, imem_req}, 32'h0);
            if (i == 4) begin
                stall_IF = 1'b0;
                imem_ack = 1'b0;
            end
            step();
        end
        for (int i = 0; i < 4; i++) begin         // ack delayed at 0x8
            check("s36_req",  {31'b0, imem_req}, 32'h1);
            check("s36_addr", imem_addr, 32'h8);
            check("s36_pc",   PC_IF, 32'h4);
            if (i == 3) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'hC0DE_0008;
            end
            step();
        end
        check("s36_pc8",  PC_IF, 32'h8);
        check("s36_addrC", imem_addr, 32'hC);

        imem_ack  = 1'b0;                          // redirect while 0xC outstanding
        PCSrc     = 1'b1;
        PC_Branch = 32'h0000_0103;
        step();
        check("s38_flush_valid", {31'b0, instr_valid}, 32'h0);
        check("s38_flush_instr", INSTRUCTION_IF, NOP);
        check("s38_hold_addr",   imem_addr, 32'hC);
        PCSrc = 1'b0;
        step();
        imem_ack   = 1'b1;
        imem_rdata = 32'hBADB_AD0C;
        step();
        check("s38_addr100", imem_addr, 32'h100);
        check("s38_still_invalid", {31'b0, instr_valid}, 32'h0);
        check("s38_discard", INSTRUCTION_IF, NOP);
        imem_rdata = 32'hC0DE_0100;
        step();
        check("s38_pc100",  PC_IF, 32'h100);
        check("s38_instr",  INSTRUCTION_IF, 32'hC0DE_0100);

        PCSrc      = 1'b1;                         // redirect + ack + stall together
        stall_IF   = 1'b1;
        PC_Branch  = 32'h0000_0100;
        imem_rdata = 32'hBAD0_0104;
        step();
        check("s39_addr",  imem_addr, 32'h100);
        check("s39_req",   {31'b0, imem_req}, 32'h1);
        check("s39_instr", INSTRUCTION_IF, 32'h0000_0013);
        check("s39_valid", {31'b0, instr_valid}, 32'h0);
        PCSrc    = 1'b0;
        stall_IF = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            step();
            reset      = ($urandom_range(0, 299) != 0);
            imem_ack   = ($urandom_range(0, 2) != 0);
            stall_IF   = ($urandom_range(0, 4) == 0);
            PCSrc      = ($urandom_range(0, 9) == 0);
            PC_Branch  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                     : $urandom;
            imem_rdata = $urandom;
        end
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
